stage1_fetch: RTL and testbench

- Fetch stage of the 3-stage pipeline. Consumer end of the branch-resolution signal produced by the stage-3 control path.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned instructions in a small FIFO toward stage 2.
- On pc_src_s3_i, redirects to the stage-3 target, flushes buffered instructions and discards any in-flight response.

---
 rtl/stage1_fetch.sv | 181 ++++++++++++++++++
 tb/tb_stage1_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage1_fetch.sv
// Purpose: generic synchronous FIFO with flush; head is read combinationally from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: the caller must not push when full unless it pops in the same cycle.
module stage1_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// Purpose: fetch PC, single-outstanding imem requester, instruction buffer toward stage 2.
// Latency: with a 1-cycle memory the head is valid two cycles after the request; 1 instr/cycle sustained.
// Backpressure: new requests are issued only when the buffer will have room; redirect flushes.
module stage1_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_src_s3_i,
  input  logic [XLEN-1:0] pc_target_s3_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_s1_o,
  input  logic            instr_ready_s2_i,
  output logic [31:0]     instr_s1_o,
  output logic [XLEN-1:0] pc_s1_o,
  output logic [XLEN-1:0] pc_plus4_s1_o
);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int FCW1 = FCW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_KILL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            active_q;
  logic            fetch_req;
  logic            push;
  logic            pop;
  logic            space;
  logic [FCW-1:0]  fifo_count;
  logic [FCW1-1:0] count_after;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            unused_target_lsbs;

  assign unused_target_lsbs = ^pc_target_s3_i[1:0];

  assign instr_valid_s1_o = (fifo_count != '0) && !pc_src_s3_i;
  assign pop              = instr_valid_s1_o && instr_ready_s2_i;
  assign push             = (state_q == S_WAIT) && imem_rvalid_i && !pc_src_s3_i;
  assign count_after      = {1'b0, fifo_count} + FCW1'(push) - FCW1'(pop);
  assign space            = count_after < FCW1'(FIFO_DEPTH);

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = imem_rdata_i;

  // active_q keeps the request line low in the first cycle out of reset.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    fetch_req = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_req = active_q && space && !pc_src_s3_i;
        if (fetch_req && imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          fetch_req = space && !pc_src_s3_i;
          if (fetch_req && imem_gnt_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_KILL: begin
        if (imem_rvalid_i) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A redirect overrides everything; an outstanding response not yet seen must be dropped later.
    if (pc_src_s3_i) begin
      pc_d = {pc_target_s3_i[XLEN-1:2], 2'b00};
      if (state_q == S_FETCH || imem_rvalid_i) state_d = S_FETCH;
      else                                     state_d = S_KILL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      active_q <= 1'b1;
    end
  end

  stage1_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (pc_src_s3_i),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .head_dat_o (head_entry),
    .count_o    (fifo_count)
  );

  assign imem_req_o    = fetch_req;
  assign imem_addr_o   = pc_q;
  assign instr_s1_o    = head_entry.instr;
  assign pc_s1_o       = head_entry.pc;
  assign pc_plus4_s1_o = head_entry.pc + XLEN'(4);
endmodule

// File: tb/tb_stage1_fetch.sv
// Bench for stage1_fetch: directed scenarios plus randomized traffic against a transaction-level model.
module tb_stage1_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_s1;
  logic [31:0] pc_plus4;

  stage1_fetch #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pc_src_s3_i      (pc_src),
    .pc_target_s3_i   (pc_target),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .instr_valid_s1_o (instr_valid),
    .instr_ready_s2_i (instr_ready),
    .instr_s1_o       (instr),
    .pc_s1_o          (pc_s1),
    .pc_plus4_s1_o    (pc_plus4)
  );

  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;

  // Reference model: fetch pointer, one outstanding-request record, and the buffer as a queue.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        q[$];
  bit          m_active;
  logic [31:0] m_pc;
  bit          o_vld;
  bit          o_kill;
  logic [31:0] o_addr;
  int          o_lat;
  int          lat;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_pc4, s_instr;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit rv, push, pop, ev, er;
    int nq;
    rv = o_vld && (o_lat == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? word(o_addr) : $urandom;
    @(negedge clk);
    ev   = (q.size() > 0) && !pc_src;
    pop  = ev && instr_ready;
    push = rv && !o_kill && !pc_src;
    nq   = q.size() + int'(push) - int'(pop);
    er   = m_active && !pc_src && (!o_vld || (rv && !o_kill)) && (nq < DEPTH);
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_pc = pc_s1; s_pc4 = pc_plus4; s_instr = instr;
    chk("req", {31'b0, s_req}, {31'b0, er});
    if (er) chk("addr", s_addr, m_pc);
    chk("valid", {31'b0, s_valid}, {31'b0, ev});
    if (ev) begin
      chk("head_pc", s_pc, q[0].pc);
      chk("head_pc4", s_pc4, q[0].pc + 32'd4);
      chk("head_instr", s_instr, q[0].ins);
    end
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_pc = RESET_PC; o_vld = 0; o_kill = 0; q.delete();
    end else begin
      m_active = 1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{o_addr, word(o_addr)});
      if (rv) o_vld = 0;
      else if (o_vld) o_lat--;
      if (pc_src) begin
        q.delete();
        m_pc = {pc_target[31:2], 2'b00};
        if (o_vld) o_kill = 1;
      end
      if (er && imem_gnt) begin
        o_vld = 1; o_kill = 0; o_addr = m_pc; o_lat = lat - 1;
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; pc_src = 0;
    cycle();
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1; pc_src = 0; pc_target = '0; imem_gnt = 1; instr_ready = 1;
    imem_rvalid = 0; imem_rdata = '0; lat = 1;
    m_active = 0; m_pc = RESET_PC; o_vld = 0; o_kill = 0; o_addr = '0; o_lat = 0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back fetch with a 1-cycle memory.
    do_reset();
    cycle(); chk("boot_req", {31'b0, s_req}, 32'd0); chk("boot_valid", {31'b0, s_valid}, 32'd0);
    cycle(); chk("s1_req0", {31'b0, s_req}, 32'd1); chk("s1_addr0", s_addr, 32'h0);
    cycle(); chk("s1_addr4", s_addr, 32'h4);
    cycle(); chk("s1_addr8", s_addr, 32'h8); chk("s1_pc0", s_pc, 32'h0); chk("s1_pc0p4", s_pc4, 32'h4);
    cycle(); chk("s1_pc4", s_pc, 32'h4); chk("s1_pc4p4", s_pc4, 32'h8);
    repeat (6) cycle();

    // Stage 2 stalls: buffer fills, requests stop, head holds.
    instr_ready = 0;
    do_reset();
    repeat (7) cycle();
    chk("s2_req_off", {31'b0, s_req}, 32'd0);
    chk("s2_head_hold", s_pc, 32'h0);
    instr_ready = 1;
    cycle(); chk("s2_pop0", s_pc, 32'h0); chk("s2_resume", s_addr, 32'h8);
    cycle(); chk("s2_pop4", s_pc, 32'h4);
    repeat (4) cycle();

    // Redirect while 0x20 is outstanding with a 3-cycle response.
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_pc == 32'h20) lat = 3;
      cycle();
      if (o_vld && o_addr == 32'h20) found = 1;
    end
    chk("s3_setup", {31'b0, found}, 32'd1);
    pc_src = 1; pc_target = 32'h100;
    cycle();
    pc_src = 0; lat = 1;
    cycle(); chk("s3_flushed", {31'b0, s_valid}, 32'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_req) found = 1;
    end
    chk("s3_req_seen", {31'b0, found}, 32'd1);
    chk("s3_target", s_addr, 32'h100);
    repeat (3) cycle();

    // Redirect in the same cycle as the response.
    lat = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_vld && o_lat == 0) found = 1;
      else cycle();
    end
    chk("s4_setup", {31'b0, found}, 32'd1);
    pc_src = 1; pc_target = 32'h203;
    cycle();
    pc_src = 0; lat = 1;
    cycle(); chk("s4_req", {31'b0, s_req}, 32'd1); chk("s4_addr", s_addr, 32'h200);
    repeat (3) cycle();

    // Two back-to-back redirects while the stale response is still in flight.
    lat = 4;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (o_vld && o_lat == 3) found = 1;
    end
    chk("s5_setup", {31'b0, found}, 32'd1);
    pc_src = 1; pc_target = 32'h40; cycle();
    pc_src = 1; pc_target = 32'h80; cycle();
    pc_src = 0; lat = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_req) found = 1;
    end
    chk("s5_req_seen", {31'b0, found}, 32'd1);
    chk("s5_addr", s_addr, 32'h80);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_valid) found = 1;
    end
    chk("s5_kept", s_pc, 32'h80);
    repeat (3) cycle();

    // Grant withheld: request and address must hold; then reset mid-stream.
    do_reset();
    for (int i = 0; i < 20 && m_pc != 32'h10; i++) cycle();
    imem_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("s6_req_hold", {31'b0, s_req}, 32'd1);
      chk("s6_addr_hold", s_addr, 32'h10);
    end
    imem_gnt = 1;
    repeat (2) cycle();
    rst = 1; cycle(); rst = 0;
    cycle(); chk("s6_rst_req", {31'b0, s_req}, 32'd0); chk("s6_rst_valid", {31'b0, s_valid}, 32'd0);
    cycle(); chk("s6_restart", s_addr, RESET_PC);

    // PC wrap at the top of the address space.
    pc_src = 1; pc_target = 32'hFFFF_FFFE; cycle(); pc_src = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_valid && s_pc == 32'hFFFF_FFFC) found = 1;
    end
    chk("s7_wrap_seen", {31'b0, found}, 32'd1);
    chk("s7_wrap_pc4", s_pc4, 32'h0);
    repeat (4) cycle();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      imem_gnt    = ($urandom_range(0, 9) < 7);
      instr_ready = ($urandom_range(0, 9) < 7);
      lat         = $urandom_range(1, 4);
      pc_src      = ($urandom_range(0, 99) < 4);
      pc_target   = $urandom;
      rst         = ($urandom_range(0, 999) < 3);
      cycle();
    end
    rst = 0; pc_src = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
